serial_adder: RTL



---
 rtl/serial_adder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder.
//   Captures a, b, cin on an in_valid/in_ready handshake. It then adds one bit
//   pair per clock, LSB first, through a single Full_Adder slice, with the carry
//   held in a flop between cycles. The result is presented on an
//   out_valid/out_ready handshake.
//   The result is ready WIDTH cycles after acceptance. With in_valid and
//   out_ready held high, a new operation can start every WIDTH+2 cycles.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid       in_ready   idle, can accept operands
//   a, b       WIDTH-bit addends    cin        carry-in
//   out_valid  result valid         out_ready  consumer takes result
//   sum        a+b+cin [WIDTH-1:0]  cout       a+b+cin [WIDTH]
//   busy       operation in flight (RUN or DONE)

// One-bit full adder slice.
//   a, b, cin  input bits
//   sum, cout  sum bit and carry-out
module Full_Adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  // The counter runs 0..WIDTH-1. It never has to hold WIDTH itself, so
  // $clog2(WIDTH) bits are enough even when WIDTH is a power of two.
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cout_r;
  logic             out_valid_r;
  logic             fa_sum;
  logic             fa_cout;

  Full_Adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      sum_sh      <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      cout_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // in_ready is 1 throughout IDLE, so in_valid alone marks acceptance.
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // The sum fills from the top by right shift. After WIDTH shifts,
          // the first (LSB) sum bit sits in bit 0.
          sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
          carry  <= fa_cout;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
            cout_r      <= fa_cout;
          end
        end
        DONE: begin
          // sum/cout are left in place after the handshake.
          if (out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = out_valid_r;
  assign sum       = sum_sh;
  assign cout      = cout_r;

endmodule
